// File: rtl/e_bloques_datos_pkg.sv
// Shared definitions for the data-block select decoder: group enum and select code ranges.
package e_bloques_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    HORA     = 3'd2,
    FECHA    = 3'd3,
    MS       = 3'd4,
    RESERVED = 3'd5
  } grupo_t;

  localparam logic [3:0] SEL_IDLE     = 4'h0;
  localparam logic [3:0] SEL_INIT_LO  = 4'h1;
  localparam logic [3:0] SEL_INIT_HI  = 4'h3;
  localparam logic [3:0] SEL_HORA_LO  = 4'h4;
  localparam logic [3:0] SEL_HORA_HI  = 4'h6;
  localparam logic [3:0] SEL_FECHA_LO = 4'h7;
  localparam logic [3:0] SEL_FECHA_HI = 4'h9;
  localparam logic [3:0] SEL_MS_LO    = 4'hA;
  localparam logic [3:0] SEL_MS_HI    = 4'hC;

  function automatic logic en_rango(input logic [3:0] sel, input logic [3:0] lo,
                                    input logic [3:0] hi);
    return (sel >= lo) && (sel <= hi);
  endfunction

endpackage

// File: rtl/e_bloques_datos_if.sv
// Select/enable bundle between the control FSM (master) and the block decoder (slave).
interface e_bloques_datos_if;
  logic [3:0] Selec_Mux_DDw;
  logic       enable_cont_I;
  logic       enable_cont_MS;
  logic       enable_cont_fecha;
  logic       enable_cont_hora;
  logic       sel_invalid;

  modport master (
    output Selec_Mux_DDw,
    input  enable_cont_I, enable_cont_MS, enable_cont_fecha, enable_cont_hora, sel_invalid
  );

  modport slave (
    input  Selec_Mux_DDw,
    output enable_cont_I, enable_cont_MS, enable_cont_fecha, enable_cont_hora, sel_invalid
  );
endinterface

// File: rtl/e_bloques_datos_decod.sv
// Combinational map from the 4-bit data-block select to its group.
module e_decod_grupo
  import e_bloques_pkg::*;
(
  input  logic [3:0] i_sel,
  output grupo_t     o_grupo
);

  always_comb begin
    o_grupo = RESERVED;
    if (i_sel == SEL_IDLE)                          o_grupo = IDLE;
    else if (en_rango(i_sel, SEL_INIT_LO,  SEL_INIT_HI))  o_grupo = INIT;
    else if (en_rango(i_sel, SEL_HORA_LO,  SEL_HORA_HI))  o_grupo = HORA;
    else if (en_rango(i_sel, SEL_FECHA_LO, SEL_FECHA_HI)) o_grupo = FECHA;
    else if (en_rango(i_sel, SEL_MS_LO,    SEL_MS_HI))    o_grupo = MS;
  end

endmodule

// File: rtl/e_bloques_datos.sv
// Registered select-to-enable decoder. Define E_BLOQUES_PULSE_EN for one-cycle enable
// pulses on group entry instead of level enables.
module e_bloques_datos
  import e_bloques_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  e_bloques_datos_if.slave bus
);

  grupo_t w_grupo;
  logic   w_nuevo;
  logic   r_en_I;
  logic   r_en_MS;
  logic   r_en_fecha;
  logic   r_en_hora;
  logic   r_sel_invalid;

  e_decod_grupo u_decod (
    .i_sel   (bus.Selec_Mux_DDw),
    .o_grupo (w_grupo)
  );

`ifdef E_BLOQUES_PULSE_EN
  grupo_t r_prev_grupo;

  always_ff @(posedge clk) begin
    if (!reset) r_prev_grupo <= IDLE;
    else        r_prev_grupo <= w_grupo;
  end

  // Enable only on the first sampled cycle of a new group.
  assign w_nuevo = (w_grupo != r_prev_grupo);
`else
  assign w_nuevo = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_en_I        <= 1'b0;
      r_en_MS       <= 1'b0;
      r_en_fecha    <= 1'b0;
      r_en_hora     <= 1'b0;
      r_sel_invalid <= 1'b0;
    end else begin
      r_en_I        <= w_nuevo && (w_grupo == INIT);
      r_en_MS       <= w_nuevo && (w_grupo == MS);
      r_en_fecha    <= w_nuevo && (w_grupo == FECHA);
      r_en_hora     <= w_nuevo && (w_grupo == HORA);
      r_sel_invalid <= (w_grupo == RESERVED);
    end
  end

  assign bus.enable_cont_I     = r_en_I;
  assign bus.enable_cont_MS    = r_en_MS;
  assign bus.enable_cont_fecha = r_en_fecha;
  assign bus.enable_cont_hora  = r_en_hora;
  assign bus.sel_invalid       = r_sel_invalid;

endmodule

// File: tb/tb_e_bloques_datos.sv
// Directed bench for e_bloques_datos; build with E_BLOQUES_PULSE_EN to exercise pulse mode.
module tb_e_bloques_datos;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  e_bloques_datos_if bus ();

  e_bloques_datos dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Observed vector: {sel_invalid, I, hora, fecha, MS}
  function automatic logic [4:0] obs();
    return {bus.sel_invalid, bus.enable_cont_I, bus.enable_cont_hora,
            bus.enable_cont_fecha, bus.enable_cont_MS};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.Selec_Mux_DDw = 4'h5;
    tick(); tick(); tick();
    checks++;
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL reset_hold: got %b want %b", obs(), 5'b00000);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs() !== 5'b00100) begin
      failures++;
      $display("FAIL reset_release: got %b want %b", obs(), 5'b00100);
    end
    tick();
    checks++;
`ifdef E_BLOQUES_PULSE_EN
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL reset_release_2nd: got %b want %b", obs(), 5'b00000);
    end
`else
    if (obs() !== 5'b00100) begin
      failures++;
      $display("FAIL reset_release_2nd: got %b want %b", obs(), 5'b00100);
    end
`endif
  endtask

  task automatic test_sweep();
    logic [4:0] exp_tab [16];
    exp_tab = '{5'b00000, 5'b01000, 5'b01000, 5'b01000,
                5'b00100, 5'b00100, 5'b00100, 5'b00010,
                5'b00010, 5'b00010, 5'b00001, 5'b00001,
                5'b00001, 5'b10000, 5'b10000, 5'b10000};
    for (int c = 0; c < 16; c++) begin
      bus.Selec_Mux_DDw = 4'(c);
      for (int k = 0; k < 10; k++) begin
        tick();
        checks++;
        if (obs() !== exp_tab[c]) begin
          failures++;
          $display("FAIL sweep sel=%h cyc=%0d: got %b want %b", c, k, obs(), exp_tab[c]);
        end
        checks++;
        if ($countones(obs() & 5'b01111) > 1) begin
          failures++;
          $display("FAIL onehot sel=%h: got %b want at most one enable", c, obs());
        end
      end
    end
  endtask

  task automatic test_wrap();
    bus.Selec_Mux_DDw = 4'hF;
    tick();
    checks++;
    if (obs() !== 5'b10000) begin
      failures++;
      $display("FAIL wrap_F: got %b want %b", obs(), 5'b10000);
    end
    bus.Selec_Mux_DDw = 4'h0;
    tick();
    checks++;
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL wrap_0: got %b want %b", obs(), 5'b00000);
    end
  endtask

  task automatic test_reset_midop();
    bus.Selec_Mux_DDw = 4'h8;
    tick();
    checks++;
    if (obs() !== 5'b00010) begin
      failures++;
      $display("FAIL midop_fecha: got %b want %b", obs(), 5'b00010);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL midop_reset: got %b want %b", obs(), 5'b00000);
    end
    reset = 1'b1;
    bus.Selec_Mux_DDw = 4'h0;
    tick();
  endtask

`ifdef E_BLOQUES_PULSE_EN
  task automatic test_pulse_init();
    logic [3:0] seq [7];
    logic [4:0] exp_seq [7];
    seq     = '{4'h1, 4'h2, 4'h3, 4'hE, 4'h2, 4'h2, 4'h2};
    exp_seq = '{5'b01000, 5'b00000, 5'b00000, 5'b10000, 5'b01000, 5'b00000, 5'b00000};
    for (int i = 0; i < 7; i++) begin
      bus.Selec_Mux_DDw = seq[i];
      tick();
      checks++;
      if (obs() !== exp_seq[i]) begin
        failures++;
        $display("FAIL pulse_init step=%0d: got %b want %b", i, obs(), exp_seq[i]);
      end
    end
  endtask

  task automatic test_pulse_reset_hold();
    int unsigned pulses = 0;
    bus.Selec_Mux_DDw = 4'hB;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (obs() !== 5'b00000) begin
      failures++;
      $display("FAIL pulse_hold_in_reset: got %b want %b", obs(), 5'b00000);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.enable_cont_MS === 1'b1) pulses++;
      if (i == 0) begin
        checks++;
        if (obs() !== 5'b00001) begin
          failures++;
          $display("FAIL pulse_hold_first: got %b want %b", obs(), 5'b00001);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL pulse_hold_count: got %0d want 1", pulses);
    end
    bus.Selec_Mux_DDw = 4'h0;
    tick();
  endtask
`endif

  initial begin
    bus.Selec_Mux_DDw = 4'h0;
    test_reset();
    test_reset_midop();
`ifdef E_BLOQUES_PULSE_EN
    test_pulse_init();
    test_pulse_reset_hold();
`else
    test_sweep();
`endif
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
